// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and the rotating-priority pick function for the AXI-Stream packet arbiter.
package axis_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PASS = 2'd1
    } arb_state_t;

    localparam int unsigned RR_MAX_N = 32;
    localparam int unsigned RR_IDX_W = 5;

    // First set request searching upward from last+1 with wrap; returns last when nothing is set.
    function automatic int unsigned rr_pick(input logic [RR_MAX_N-1:0] req,
                                            input int unsigned         last,
                                            input int unsigned         n);
        int unsigned idx;
        logic        found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
            idx = (last + k) % n;
            if (!found && (k <= n) && req[idx[RR_IDX_W-1:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_select.sv
// Combinational rotating-priority encoder; reusable by any round-robin arbiter up to 32 requesters.
module rr_priority_select
    import axis_arb_pkg::*;
#(
    parameter int unsigned N_INPUTS = 2
) (
    input  logic [N_INPUTS-1:0]         i_req,
    input  logic [$clog2(N_INPUTS)-1:0] i_last_grant,
    output logic                        o_any_req,
    output logic [$clog2(N_INPUTS)-1:0] o_winner
);

    localparam int unsigned IDX_W = $clog2(N_INPUTS);

    always_comb begin
        o_any_req = |i_req;
        o_winner  = IDX_W'(rr_pick(RR_MAX_N'(i_req), 32'(i_last_grant), N_INPUTS));
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXIS sink between N_INPUTS sources.
// Define AXIS_ARB_TID_EN to add the axis_o_tid output carrying the granted source index.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned N_INPUTS   = 2,
    parameter int unsigned AXIS_BYTES = 1
) (
    input  logic                             clk,
    input  logic                             sresetn,
    output logic [N_INPUTS-1:0]              axis_i_tready,
    input  logic [N_INPUTS-1:0]              axis_i_tvalid,
    input  logic [N_INPUTS-1:0]              axis_i_tlast,
    input  logic [N_INPUTS*AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic                             axis_o_tready,
    output logic                             axis_o_tvalid,
    output logic                             axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]          axis_o_tdata
`ifdef AXIS_ARB_TID_EN
    ,
    output logic [$clog2(N_INPUTS)-1:0]      axis_o_tid
`endif
);

    localparam int unsigned DW    = AXIS_BYTES * 8;
    localparam int unsigned IDX_W = $clog2(N_INPUTS);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic             w_any_req;
    logic [IDX_W-1:0] w_winner;
    logic             w_eop;

    rr_priority_select #(
        .N_INPUTS (N_INPUTS)
    ) u_rr_select (
        .i_req        (axis_i_tvalid),
        .i_last_grant (r_last_grant),
        .o_any_req    (w_any_req),
        .o_winner     (w_winner)
    );

    // Winner passes straight through while a packet is in flight; everything is quiet in IDLE.
    always_comb begin
        axis_i_tready = '0;
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = 1'b0;
        axis_o_tdata  = '0;
`ifdef AXIS_ARB_TID_EN
        axis_o_tid    = '0;
`endif
        if (r_state == ARB_PASS) begin
            axis_o_tvalid          = axis_i_tvalid[r_grant];
            axis_o_tlast           = axis_i_tlast[r_grant];
            axis_o_tdata           = axis_i_tdata[32'(r_grant)*DW +: DW];
            axis_i_tready[r_grant] = axis_o_tready;
`ifdef AXIS_ARB_TID_EN
            axis_o_tid             = r_grant;
`endif
        end
    end

    assign w_eop = axis_o_tvalid & axis_o_tready & axis_o_tlast;

    // Grant is held until the tlast handshake; new requests are only looked at in IDLE.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_state      <= ARB_IDLE;
            r_grant      <= IDX_W'(N_INPUTS - 1);
            r_last_grant <= IDX_W'(N_INPUTS - 1);
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_winner;
                        r_state <= ARB_PASS;
                    end
                end
                ARB_PASS: begin
                    if (w_eop) begin
                        r_last_grant <= r_grant;
                        r_state      <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
